// File: rtl/rv_pkg.sv
// Shared RV32I definitions for the fetch and decode stages.
// Holds the architectural NOP, the default reset PC, the major opcode
// constants used by decode, and the {instr, pc} packet type that fetch
// buffers and hands to decode.
package rv_pkg;

  localparam logic [31:0] RV_NOP      = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [31:0] RV_RESET_PC = 32'h0000_0000;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch packets with a single-cycle flush.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             empties the FIFO at the next edge (wins over push/pop)
//   push, push_pkt    write a packet; accepted when not full, or when full
//                     and popping in the same cycle
//   pop               drop the head packet; ignored when empty
//   head_pkt          current head (meaningless while empty)
//   count, full, empty  occupancy
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  fetch_pkt_t    push_pkt,
  input  logic          pop,
  output fetch_pkt_t    head_pkt,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_pkt_t    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign count    = count_q;
  assign head_pkt = mem[rd_ptr];

  assign do_pop  = pop & ~empty;
  // A full FIFO may still take a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset; the occupancy count decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_pkt;
  end

  overflow_a : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !pop && !flush));

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction fetch stage.
// Owns the PC, issues word-aligned requests to instruction memory, tags each
// in-order response with its PC and buffers it for decode. Redirects from
// execute flush the buffer and mark every in-flight request as stale.
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   imem_req_valid/addr/ready           fetch request channel
//   imem_rsp_valid/data                 in-order response channel (latency >= 1)
//   redirect_valid, redirect_pc         restart fetch at a new PC
//   instr_valid/ready, instr, instr_pc  instruction channel to decode
module fetch_unit
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RV_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [31:0]   fetch_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_nxt;
  logic [CW-1:0] discard;
  logic [CW:0]   credit_used;
  logic          credit_ok;
  logic          req_fire;
  logic          rsp_keep;

  fetch_pkt_t    buf_head;
  logic [CW-1:0] buf_count;
  logic          buf_full;
  logic          buf_empty;
  fetch_pkt_t    shown_pkt;

  fetch_pkt_t    pcq_head;
  logic [CW-1:0] pcq_count;
  logic          pcq_full;
  logic          pcq_empty;
  logic          unused_status;

  // Credits come from registered occupancy only; a pop this cycle does not
  // free a slot until the next cycle.
  assign credit_used = {1'b0, outstanding} + {1'b0, buf_count};
  assign credit_ok   = (credit_used < (CW+1)'(FIFO_DEPTH));

  // rst_n gates the request so nothing is presented while reset is held,
  // yet the first request is accepted on the first edge after release.
  assign imem_req_valid = rst_n & credit_ok & ~redirect_valid;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid & imem_req_ready;

  // Responses are dropped while stale ones remain, and in a redirect cycle.
  assign rsp_keep = imem_rsp_valid & (discard == '0) & ~redirect_valid;

  assign outstanding_nxt = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect_valid) begin
        fetch_pc <= {redirect_pc[31:2], 2'b00};
        // outstanding already counts requests made stale by an earlier
        // redirect, so everything still in flight after this edge is stale.
        discard  <= outstanding_nxt;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (imem_rsp_valid && (discard != '0)) discard <= discard - CW'(1);
      end
    end
  end

  // In-flight PC queue: one entry per accepted request, popped by every
  // response (kept or dropped), so its head always tags the current response.
  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_pc_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (1'b0),
    .push     (req_fire),
    .push_pkt (fetch_pkt_t'{instr: 32'h0, pc: fetch_pc}),
    .pop      (imem_rsp_valid),
    .head_pkt (pcq_head),
    .count    (pcq_count),
    .full     (pcq_full),
    .empty    (pcq_empty)
  );

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_instr_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect_valid),
    .push     (rsp_keep),
    .push_pkt (fetch_pkt_t'{instr: imem_rsp_data, pc: pcq_head.pc}),
    .pop      (instr_valid & instr_ready),
    .head_pkt (buf_head),
    .count    (buf_count),
    .full     (buf_full),
    .empty    (buf_empty)
  );

  // Remembers the last presented packet so decode sees stable values while
  // the buffer is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shown_pkt <= '{instr: RV_NOP, pc: RESET_PC};
    end else if (!buf_empty) begin
      shown_pkt <= buf_head;
    end
  end

  assign instr_valid = ~buf_empty & ~redirect_valid;
  assign instr       = buf_empty ? shown_pkt.instr : buf_head.instr;
  assign instr_pc    = buf_empty ? shown_pkt.pc    : buf_head.pc;

  assign unused_status = ^{pcq_head.instr, pcq_count, pcq_full, pcq_empty, buf_full};

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import rv_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 1;
  int p_mready = 100;
  int p_iready = 100;
  int first_iv = -1;

  // Reference model: PC, in-flight requests (with stale flag), decode buffer.
  logic [31:0] m_pc;
  logic [31:0] m_infl[$];
  bit          m_stale[$];
  logic [31:0] m_fifo[$];
  // Memory model: accepted addresses and the cycle each response is due.
  logic [31:0] mem_addr[$];
  int          mem_due[$];
  logic [31:0] acc_log[$];
  logic [31:0] dlv_log[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h1357, ~a[15:0]};
  endfunction

  function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_inputs();
    imem_req_ready = (int'($urandom_range(99)) < p_mready);
    instr_ready    = (int'($urandom_range(99)) < p_iready);
    redirect_valid = 1'b0;
    redirect_pc    = $urandom;
    if (mem_addr.size() > 0 && mem_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_addr[0]);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
  endtask

  // One clock: compare outputs against the model, advance model and memory.
  task automatic step();
    bit exp_rv, exp_iv, fire, pop, rsp, rdr, st;
    logic [31:0] rpc, tag;
    #1;
    exp_rv = (m_infl.size() + m_fifo.size() < DEPTH) && !redirect_valid;
    exp_iv = (m_fifo.size() > 0) && !redirect_valid;
    chk("req_valid", imem_req_valid, exp_rv);
    if (exp_rv) chk("req_addr", imem_req_addr, m_pc);
    chk("instr_valid", instr_valid, exp_iv);
    if (exp_iv) begin
      chk("instr_pc", instr_pc, m_fifo[0]);
      chk("instr", instr, mem_word(m_fifo[0]));
    end
    if (instr_valid && first_iv < 0) first_iv = cyc;
    fire = exp_rv && imem_req_ready;
    pop  = exp_iv && instr_ready;
    rsp  = imem_rsp_valid;
    rdr  = redirect_valid;
    rpc  = redirect_pc;
    @(posedge clk);
    if (pop) dlv_log.push_back(m_fifo.pop_front());
    if (rsp && m_infl.size() > 0) begin
      st  = m_stale.pop_front();
      tag = m_infl.pop_front();
      void'(mem_addr.pop_front());
      void'(mem_due.pop_front());
      if (!st && !rdr) m_fifo.push_back(tag);
    end
    if (fire) begin
      m_infl.push_back(m_pc);
      m_stale.push_back(1'b0);
      mem_addr.push_back(m_pc);
      mem_due.push_back(cyc + lat);
      acc_log.push_back(m_pc);
      m_pc = m_pc + 32'd4;
    end
    if (rdr) begin
      foreach (m_stale[i]) m_stale[i] = 1'b1;
      m_fifo.delete();
      m_pc = {rpc[31:2], 2'b00};
    end
    cyc++;
    #1 drive_inputs();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_instr_valid", instr_valid, 1'b0);
    chk("rst_instr", instr, RV_NOP);
    chk("rst_instr_pc", instr_pc, RV_RESET_PC);
    m_pc = RV_RESET_PC;
    m_infl.delete();
    m_stale.delete();
    m_fifo.delete();
    mem_addr.delete();
    mem_due.delete();
    acc_log.delete();
    dlv_log.delete();
    first_iv = -1;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    drive_inputs();
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    step();
  endtask

  initial begin
    int  n;
    bit  found;

    // Straight-line fetch, 1-cycle memory, decode always ready.
    lat = 1; p_mready = 100; p_iready = 100;
    #2 do_reset();
    steps(20);
    chk("p1_first_valid_cycle", first_iv, 2);
    chk("p1_acc0", at(acc_log, 0), 32'h0);
    chk("p1_acc1", at(acc_log, 1), 32'h4);
    chk("p1_acc2", at(acc_log, 2), 32'h8);
    chk("p1_dlv0", at(dlv_log, 0), 32'h0);
    chk("p1_dlv1", at(dlv_log, 1), 32'h4);

    // Decode stalled: only two fetches, buffer holds 0x0 and 0x4.
    p_iready = 0;
    do_reset();
    steps(10);
    chk("p2_accept_count", acc_log.size(), 2);
    chk("p2_req_blocked", imem_req_valid, 1'b0);
    chk("p2_head_pc", instr_pc, 32'h0);
    p_iready = 100;
    steps(4);
    chk("p2_dlv0", at(dlv_log, 0), 32'h0);
    chk("p2_dlv1", at(dlv_log, 1), 32'h4);

    // Latency 3, redirect with two requests in flight.
    lat = 3;
    do_reset();
    n = 0;
    while (m_infl.size() < 2 && n < 20) begin step(); n++; end
    chk("p3_two_outstanding", m_infl.size(), 2);
    dlv_log.delete();
    do_redirect(32'h0000_0100);
    steps(20);
    chk("p3_first_after_redirect", at(dlv_log, 0), 32'h100);
    chk("p3_second_after_redirect", at(dlv_log, 1), 32'h104);

    // Redirect coinciding with a response and a decode handshake.
    lat = 1;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (imem_rsp_valid && m_fifo.size() > 0 && instr_ready) begin
        found = 1'b1;
        dlv_log.delete();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        #1 chk("p4_valid_masked", instr_valid, 1'b0);
        step();
      end else begin
        step();
      end
    end
    chk("p4_found_collision", found, 1'b1);
    steps(10);
    chk("p4_first_after_redirect", at(dlv_log, 0), 32'h300);

    // Misaligned target and address wrap.
    acc_log.delete();
    do_redirect(32'h0000_0203);
    steps(6);
    chk("p5_aligned_target", at(acc_log, 0), 32'h200);
    acc_log.delete();
    do_redirect(32'hFFFF_FFFC);
    steps(8);
    chk("p5_wrap_first", at(acc_log, 0), 32'hFFFF_FFFC);
    chk("p5_wrap_second", at(acc_log, 1), 32'h0);

    // Randomized traffic against the model.
    p_mready = 70; p_iready = 60;
    for (int blk = 0; blk < 15; blk++) begin
      lat = 1 + int'($urandom_range(3));
      for (int i = 0; i < 200; i++) begin
        if ($urandom_range(99) < 6) begin
          redirect_valid = 1'b1;
          redirect_pc    = $urandom;
        end
        step();
      end
    end

    // Asynchronous reset with the buffer full.
    lat = 4; p_mready = 100; p_iready = 0;
    do_reset();
    steps(12);
    chk("p7_full_before_reset", instr_valid, 1'b1);
    chk("p7_req_blocked", imem_req_valid, 1'b0);
    p_iready = 100;
    do_reset();
    steps(3);
    chk("p7_first_after_reset", at(acc_log, 0), RV_RESET_PC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end

endmodule
